// File: rtl/addsub_pkg.sv
// Shared encodings for the serial add/subtract unit: op codes, FSM states, flag bit positions.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/addsub_serial_chunk.sv
// Combinational CHUNK-bit carry-lookahead adder; c_msb is the carry into the top bit for overflow.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_c;

    // Each carry is the flat OR of generate terms masked by the propagates above them.
    function automatic logic carry_at(input logic [CHUNK-1:0] g,
                                      input logic [CHUNK-1:0] p,
                                      input logic             c0,
                                      input int               n);
        logic acc;
        logic term;
        acc = c0;
        for (int k = 0; k < n; k++) acc = acc & p[k];
        for (int j = 0; j < n; j++) begin
            term = g[j];
            for (int k = j + 1; k < n; k++) term = term & p[k];
            acc = acc | term;
        end
        return acc;
    endfunction

    assign w_g = x & y;
    assign w_p = x ^ y;

    always_comb begin
        w_c = '0;
        for (int i = 0; i <= CHUNK; i++) begin
            w_c[i] = carry_at(w_g, w_p, cin, i);
        end
    end

    assign sum   = w_p ^ w_c[CHUNK-1:0];
    assign cout  = w_c[CHUNK];
    assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract, CHUNK bits per cycle LSB first, with N/Z/C/V flags and valid/ready.
// Optional saturation on signed overflow is enabled by defining ADDSUB_SAT_EN (adds the sat port).
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int ANCHO = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             op,
    input  logic             aluflagin,
`ifdef ADDSUB_SAT_EN
    input  logic             sat,
`endif
    output logic [ANCHO-1:0] aluresult,
    output logic [3:0]       aluflags,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NCHUNK = ANCHO / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ANCHO-1:0]   r_a;
    logic [ANCHO-1:0]   r_b;
    logic [ANCHO-1:0]   r_res;
    logic [3:0]         r_flags;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic [CHUNK-1:0]   w_x;
    logic [CHUNK-1:0]   w_y;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_cmsb;
    logic               w_v;
    logic [ANCHO-1:0]   w_res_nxt;
    logic [ANCHO-1:0]   w_res_fin;
    logic [3:0]         w_flags_fin;

`ifdef ADDSUB_SAT_EN
    logic               r_sat;

    // Wrapped MSB set on overflow means the true result was positive, and vice versa.
    function automatic logic [ANCHO-1:0] sat_clamp(input logic wrapped_msb);
        if (wrapped_msb) return {1'b0, {(ANCHO-1){1'b1}}};
        return {1'b1, {(ANCHO-1){1'b0}}};
    endfunction
`endif

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_state == BUSY) && (r_cnt == CNT_W'(NCHUNK - 1));

    assign w_x = r_a[r_cnt*CHUNK +: CHUNK];
    assign w_y = r_b[r_cnt*CHUNK +: CHUNK];

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x     (w_x),
        .y     (w_y),
        .cin   (r_carry),
        .sum   (w_sum),
        .cout  (w_cout),
        .c_msb (w_cmsb)
    );

    assign w_v = w_cmsb ^ w_cout;

    always_comb begin
        w_res_nxt = r_res;
        w_res_nxt[r_cnt*CHUNK +: CHUNK] = w_sum;
        w_res_fin = w_res_nxt;
`ifdef ADDSUB_SAT_EN
        if (r_sat && w_v) w_res_fin = sat_clamp(w_res_nxt[ANCHO-1]);
`endif
        w_flags_fin        = '0;
        w_flags_fin[FLG_N] = w_res_fin[ANCHO-1];
        w_flags_fin[FLG_Z] = ~|w_res_fin;
        w_flags_fin[FLG_C] = w_cout;
        w_flags_fin[FLG_V] = w_v;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Result, flags and chaining state; reset wipes any partially built result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_flags <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_carry <= aluflagin;
        end else if (r_state == BUSY) begin
            r_carry <= w_cout;
            if (w_last) begin
                r_cnt   <= '0;
                r_res   <= w_res_fin;
                r_flags <= w_flags_fin;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_res   <= w_res_nxt;
            end
        end
    end

    // Operands are captured at accept; subtraction stores the complemented B.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= (op == OP_SUB) ? ~b : b;
`ifdef ADDSUB_SAT_EN
            r_sat <= sat;
`endif
        end
    end

    assign aluresult = r_res;
    assign aluflags  = r_flags;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed self-checking bench for addsub_serial (ANCHO=16, CHUNK=4).
module tb_addsub_serial;

    localparam int ANCHO = 16;
    localparam int CHUNK = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [ANCHO-1:0] a;
    logic [ANCHO-1:0] b;
    logic             op;
    logic             aluflagin;
    logic [ANCHO-1:0] aluresult;
    logic [3:0]       aluflags;
    logic             out_valid;
    logic             out_ready;
`ifdef ADDSUB_SAT_EN
    logic             sat;
`endif

    int n_pass;
    int n_checks;

    addsub_serial #(
        .ANCHO (ANCHO),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .aluflagin (aluflagin),
`ifdef ADDSUB_SAT_EN
        .sat       (sat),
`endif
        .aluresult (aluresult),
        .aluflags  (aluflags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation (caller must be in IDLE, just after a posedge) and wait for out_valid.
    task automatic run_op(input logic [ANCHO-1:0] va, input logic [ANCHO-1:0] vb,
                          input logic vop, input logic vcin, output int lat);
        a = va; b = vb; op = vop; aluflagin = vcin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (aluresult !== 16'h0000) $display("FAIL reset_result got %h want 0000", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b0000) $display("FAIL reset_flags got %b want 0000", aluflags); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int lat;
        run_op(16'h1234, 16'h0FED, 1'b0, 1'b0, lat);
        n_checks++; if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat); else n_pass++;
        n_checks++; if (aluresult !== 16'h2221) $display("FAIL add_result got %h want 2221", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b0000) $display("FAIL add_flags got %b want 0000", aluflags); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL add_in_ready_done got %b want 0", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL add_in_ready_after got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL add_out_valid_after got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_sub_negative();
        int lat;
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
        n_checks++; if (aluresult !== 16'hFFFE) $display("FAIL subneg_result got %h want fffe", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b1000) $display("FAIL subneg_flags got %b want 1000", aluflags); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_sub_overflow();
        int lat;
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, lat);
        n_checks++; if (aluresult !== 16'h7FFF) $display("FAIL subovf_result got %h want 7fff", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b0011) $display("FAIL subovf_flags got %b want 0011", aluflags); else n_pass++;
        @(posedge clk); #1;
`ifdef ADDSUB_SAT_EN
        sat = 1'b1;
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, lat);
        n_checks++; if (aluresult !== 16'h8000) $display("FAIL sat_neg_result got %h want 8000", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b1011) $display("FAIL sat_neg_flags got %b want 1011", aluflags); else n_pass++;
        @(posedge clk); #1;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        n_checks++; if (aluresult !== 16'h7FFF) $display("FAIL sat_pos_result got %h want 7fff", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b0001) $display("FAIL sat_pos_flags got %b want 0001", aluflags); else n_pass++;
        @(posedge clk); #1;
        sat = 1'b0;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
        n_checks++; if (aluresult !== 16'h8000) $display("FAIL nosat_result got %h want 8000", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b1001) $display("FAIL nosat_flags got %b want 1001", aluflags); else n_pass++;
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_add_wrap();
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        n_checks++; if (aluresult !== 16'h0000) $display("FAIL wrap_result got %h want 0000", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b0110) $display("FAIL wrap_flags got %b want 0110", aluflags); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        a = 16'h1234; b = 16'h0FED; op = 1'b0; aluflagin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            a = 16'($urandom); b = 16'($urandom); op = ~op; aluflagin = ~aluflagin;
            @(posedge clk); #1;
            lat++;
        end
        n_checks++; if (lat !== 4) $display("FAIL bp_latency got %0d want 4", lat); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom); b = 16'($urandom); op = ~op; aluflagin = ~aluflagin;
            @(posedge clk); #1;
            n_checks++; if (aluresult !== 16'h2221) $display("FAIL bp_result[%0d] got %h want 2221", i, aluresult); else n_pass++;
            n_checks++; if (aluflags !== 4'b0000) $display("FAIL bp_flags[%0d] got %b want 0000", i, aluflags); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); else n_pass++;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int lat;
        a = 16'hAAAA; b = 16'h5557; op = 1'b0; aluflagin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (aluresult !== 16'h0000) $display("FAIL midrst_result got %h want 0000", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b0000) $display("FAIL midrst_flags got %b want 0000", aluflags); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_no_partial got %b want 0", out_valid); else n_pass++;
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        n_checks++; if (lat !== 4) $display("FAIL post_rst_latency got %0d want 4", lat); else n_pass++;
        n_checks++; if (aluresult !== 16'h0002) $display("FAIL post_rst_result got %h want 0002", aluresult); else n_pass++;
        n_checks++; if (aluflags !== 4'b0000) $display("FAIL post_rst_flags got %b want 0000", aluflags); else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = 1'b0;
        aluflagin = 1'b0;
        out_ready = 1'b1;
`ifdef ADDSUB_SAT_EN
        sat = 1'b0;
`endif
        test_reset();
        test_add();
        test_sub_negative();
        test_sub_overflow();
        test_add_wrap();
        test_backpressure();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle add/subtract unit. Next generation of the team's fixed 4-bit combinational subtractor.
- Processes an ANCHO-bit operand pair CHUNK bits per cycle, LSB chunk first, with carry/borrow chained across cycles.
- Produces registered result plus N/Z/C/V flags behind a valid/ready handshake.
- Sits between the ALU operand registers and the result writeback.

Parameters:
- ANCHO, 16, operand/result width; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; NCHUNK = ANCHO/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept.
- a  input  ANCHO  operand A.
- b  input  ANCHO  operand B.
- op  input  1  0 = add, 1 = subtract.
- aluflagin  input  1  carry in. Add: a+b+aluflagin. Sub: a+~b+aluflagin (1 = no borrow).
- aluresult  output  ANCHO  registered result.
- aluflags  output  4  {N,Z,C,V}, bit3..bit0.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - aluresult = 0, aluflags = 0, out_valid = 0, in_ready = 1.
  - Chunk counter and carry register clear.
  - Reset mid-operation discards the in-flight op; no partial result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready:
    - Latch a.
    - Latch b, or ~b if op = 1.
    - Latch aluflagin into the carry register.
    - Counter <= 0; go to BUSY.
- BUSY:
  - in_ready = 0; inputs are ignored (operands already latched).
  - Each cycle, add chunk[counter] of A and B' plus carry; write the sum into that result chunk; carry <= chunk carry-out; counter++.
  - After the chunk with index NCHUNK-1 is written, go to DONE.
- DONE:
  - out_valid = 1.
  - aluresult and aluflags are held stable until out_valid & out_ready; then go to IDLE on that edge.
- Latency:
  - Accept at edge k; out_valid rises after edge k+NCHUNK.
  - ANCHO = CHUNK gives 1 cycle.
  - Minimum issue interval is NCHUNK+2 cycles (no overlap of accept with DONE).
- Flags, computed on the final chunk and registered with the result:
  - N = result[ANCHO-1].
  - Z = (result == 0).
  - C = carry out of the MSB (for sub, 1 = no borrow).
  - V = carry into MSB XOR carry out of MSB.
- Arithmetic wraps modulo 2^ANCHO unless the optional feature applies.
- aluresult may be built in place during BUSY, but out_valid gates validity. Flags update only on the BUSY->DONE edge.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - Extra input port sat (1 bit), latched at accept.
  - If sat = 1 and V = 1, aluresult clamps to 0x7F..F when the true result is positive overflow, 0x80..0 when negative overflow.
  - V is still reported as 1; N and Z reflect the clamped value.
  - sat = 0 behaves as wrap.
- Undefined: no sat port; wrap-around only.

Decomposition:
- Package addsub_pkg holds:
  - op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - FSM state enum {IDLE, BUSY, DONE};
  - flag index constants FLG_N = 3, FLG_Z = 2, FLG_C = 1, FLG_V = 0.
- One sub-module, addsub_chunk: combinational CHUNK-bit carry-lookahead adder. Inputs: x, y, cin. Outputs: sum, cout, and c_msb (carry into its top bit, used for V).

Test Plan (ANCHO = 16, CHUNK = 4):
- add 0x1234 + 0x0FED, aluflagin = 0 -> aluresult 0x2221, flags 0000; out_valid exactly 4 cycles after accept.
- sub 0x0005 - 0x0007, aluflagin = 1 -> 0xFFFE, N = 1, Z = 0, C = 0, V = 0.
- sub 0x8000 - 0x0001, aluflagin = 1 -> 0x7FFF, N = 0, C = 1, V = 1. With ADDSUB_SAT_EN and sat = 1 -> 0x8000, V = 1, N = 1.
- add 0xFFFF + 0x0001, aluflagin = 0 -> 0x0000, Z = 1, C = 1, V = 0, N = 0.
- Backpressure: out_ready low for 5 cycles after out_valid -> aluresult and aluflags stable, in_ready = 0. Toggling in_valid/a/b during BUSY and DONE does not change the result. out_ready high -> in_ready = 1 next cycle.
- rst pulsed asynchronously in BUSY (after 2 chunks) -> out_valid = 0, aluresult = 0, aluflags = 0 immediately. A following add 0x0001 + 0x0001 returns 0x0002 with no residue from the aborted op.
